window_generator: RTL

Upstream feeder of the 3×3 smoothing stage. Accepts a raster pixel stream two pixels per cycle and buffers two previous lines. Emits, per accepted pair, the two 3×3 neighbourhoods (9 taps × 2 lanes, 8 bit) in exactly the tap/lane layout the smoothing stage consumes. Honours the smoothing stage's `stall` so windows are never lost.

---
 rtl/img_pkg.sv | 24 ++
 rtl/window_generator_if.sv | 23 ++
 rtl/line_buffer.sv | 26 ++
 rtl/window_generator.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/img_pkg.sv
// Pixel, pair, column and window types shared by the window generator and the smoothing stage.
// Tap j = 3*row + col (row 0 = top), lane i = centre column 2k+i.
package img_pkg;

  localparam int PIX_LANES = 2;
  localparam int WIN_TAPS  = 9;
  localparam int WIN_ROWS  = 3;

  typedef logic [7:0] pix_t;
  typedef pix_t [PIX_LANES-1:0] pair_t;
  typedef pair_t [WIN_ROWS-1:0] col_t;
  typedef pair_t [WIN_TAPS-1:0] win_t;

  typedef enum logic [1:0] {
    FILL,
    RUN,
    FLUSH
  } win_state_e;

  function automatic int tap_idx(input int r, input int c);
    return WIN_ROWS * r + c;
  endfunction

endpackage

// File: rtl/window_generator_if.sv
// Pixel-pair input handshake plus stall-held window output bundle.
interface window_generator_if;
  import img_pkg::*;

  pair_t pix_in;
  logic  pix_valid;
  logic  in_ready;
  logic  stall;
  win_t  window;
  logic  win_valid;
  logic  win_last;

  modport master (
    output pix_in, pix_valid, stall,
    input  in_ready, window, win_valid, win_last
  );

  modport slave (
    input  pix_in, pix_valid, stall,
    output in_ready, window, win_valid, win_last
  );

endinterface

// File: rtl/line_buffer.sv
// One line of pixel pairs: combinational read and registered write at the same address.
// Contents are never reset; the generator never emits a window that reads a stale entry.
module line_buffer
  import img_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  pair_t         wdata_i,
  output pair_t         rdata_o
);

  pair_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/window_generator.sv
// Builds two 3x3 neighbourhoods per accepted pixel pair; registered output one cycle after the forming edge.
// stall freezes accept, FSM, counters and outputs; one in_ready-low FLUSH cycle per line emits the right-edge window.
module window_generator
  import img_pkg::*;
#(
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 64
) (
  input  logic clk,
  input  logic reset,
  window_generator_if.slave bus
);

  localparam int PAIRS = IMG_WIDTH / 2;
  localparam int KW    = $clog2(PAIRS);
  localparam int YW    = $clog2(IMG_HEIGHT);
  localparam logic [KW-1:0] K_LAST = KW'(PAIRS - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);

  win_state_e    state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [YW-1:0] y_q, y_d;
  col_t          prev_q, prev_d, cur_q, cur_d, inc;
  pair_t         lb_old_rd, lb_new_rd;
  win_t          win_q, win_d;
  logic          win_vld_q, win_last_q;
  logic          in_ready, accept, emit, flush_last, clamp_l, clamp_r;

  assign in_ready = !bus.stall && (state_q != FLUSH);
  assign accept   = bus.pix_valid && in_ready;
  assign inc      = {bus.pix_in, lb_new_rd, lb_old_rd};

  line_buffer #(.DEPTH(PAIRS), .AW(KW)) u_lb_old (
    .clk     (clk),
    .we_i    (accept),
    .addr_i  (k_q),
    .wdata_i (lb_new_rd),
    .rdata_o (lb_old_rd)
  );

  line_buffer #(.DEPTH(PAIRS), .AW(KW)) u_lb_new (
    .clk     (clk),
    .we_i    (accept),
    .addr_i  (k_q),
    .wdata_i (bus.pix_in),
    .rdata_o (lb_new_rd)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FILL;
      k_q     <= '0;
      y_q     <= '0;
      prev_q  <= '0;
      cur_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      y_q     <= y_d;
      prev_q  <= prev_d;
      cur_q   <= cur_d;
    end
  end

  // Counters already point past the line when FLUSH runs, so y_q == 0 means the frame wrapped.
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    y_d        = y_q;
    prev_d     = prev_q;
    cur_d      = cur_q;
    emit       = 1'b0;
    flush_last = 1'b0;
    if (accept) begin
      prev_d = cur_q;
      cur_d  = inc;
      if (k_q == K_LAST) begin
        k_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
      end else begin
        k_d = k_q + 1'b1;
      end
    end
    unique case (state_q)
      FILL: begin
        if (accept && (k_q == K_LAST) && (y_q == YW'(1))) begin
          state_d = RUN;
        end
      end
      RUN: begin
        emit = accept && (k_q != '0);
        if (accept && (k_q == K_LAST)) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (!bus.stall) begin
          emit       = 1'b1;
          flush_last = (y_q == '0);
          state_d    = (y_q == '0) ? FILL : RUN;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // cur_q holds the centre pair, prev_q the pair to its left, inc the pair to its right.
  assign clamp_l = (k_q == KW'(1));
  assign clamp_r = (state_q == FLUSH);

  always_comb begin
    win_d = '0;
    for (int r = 0; r < WIN_ROWS; r++) begin
      win_d[tap_idx(r, 0)][0] = clamp_l ? cur_q[r][0] : prev_q[r][1];
      win_d[tap_idx(r, 1)][0] = cur_q[r][0];
      win_d[tap_idx(r, 2)][0] = cur_q[r][1];
      win_d[tap_idx(r, 0)][1] = cur_q[r][0];
      win_d[tap_idx(r, 1)][1] = cur_q[r][1];
      win_d[tap_idx(r, 2)][1] = clamp_r ? cur_q[r][1] : inc[r][0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win_q      <= '0;
      win_vld_q  <= 1'b0;
      win_last_q <= 1'b0;
    end else if (!bus.stall) begin
      win_vld_q  <= emit;
      win_last_q <= flush_last;
      if (emit) begin
        win_q <= win_d;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.window    = win_q;
  assign bus.win_valid = win_vld_q;
  assign bus.win_last  = win_last_q;

endmodule
